truth_table_scanner: RTL

Sequential scan stage that sits directly upstream of a 3-input combinational gate such as `custom_gate_1`. It drives every input code 0 … 2^WIDTH−1 onto the gate and holds each code for a configurable number of cycles. On the last hold cycle of each code it samples the gate's output F and builds the gate's truth table in a register. One start pulse runs one complete sweep, and `done` reports completion for characterising or self-checking gate instances.

---
 rtl/truth_scan_pkg.sv | 17 +
 rtl/scan_hold_timer.sv | 36 +++
 rtl/truth_table_scanner.sv | 138 +++++++++++++
 3 files changed

// File: rtl/truth_scan_pkg.sv
// Purpose: shared state encoding and sizing helper for the truth-table scanner.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package truth_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_e;

  // Hold counter width: max(1, clog2(hold)); a 1- or 2-cycle hold still needs one bit.
  function automatic int hold_cnt_w(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/scan_hold_timer.sv
// Purpose: per-code hold down-counter; expire is high on the last hold cycle.
// Latency: load takes effect on the next edge; expire is decoded from the count register.
// Backpressure: none; counts every cycle while run is high, reloads itself on expiry.
module scan_hold_timer
  import truth_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = hold_cnt_w(HOLD_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] r_count;

  // Count down to zero, then reload so consecutive codes get equal hold time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= RELOAD;
    end else if (run) begin
      if (expire) r_count <= RELOAD;
      else        r_count <= r_count - ONE;
    end
  end

  assign expire = (r_count == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Purpose: sweeps every input code onto a combinational gate and captures its truth table.
// Latency: start to done is 2^WIDTH*HOLD_CYCLES+1 cycles; all outputs come straight from registers.
// Backpressure: none; start is ignored unless idle, abort only acts while driving.
// Optional: define TRUTH_SCAN_COMPARE_EN to build the expected-table register and pass flag.
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  f,
  input  logic [2**WIDTH-1:0]   expected,
  output logic [WIDTH-1:0]      abc,
  output logic [2**WIDTH-1:0]   table_q,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
);

  localparam int              N    = 2**WIDTH;
  localparam logic [WIDTH-1:0] LAST = {WIDTH{1'b1}};

  scan_state_e      r_state;
  scan_state_e      w_next_state;
  logic [WIDTH-1:0] r_abc;
  logic [N-1:0]     r_table;
  logic [N-1:0]     w_table_cap;
  logic             w_expire;
  logic             w_accept;
  logic             w_capture;
  logic             w_abort;
  logic             w_end;
  logic             w_driving;

  assign w_driving = (r_state == ST_DRIVE);

  scan_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_accept),
    .run    (w_driving),
    .expire (w_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and sweep control; abort beats the terminal capture so no done/pass follows.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    w_end        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        w_capture = w_expire;
        if (abort) begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_expire && (r_abc == LAST)) begin
          w_end        = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Table as it will look after this edge; shared by the table register and the compare.
  always_comb begin
    w_table_cap = r_table;
    if (w_capture) w_table_cap[r_abc] = f;
  end

  // Code driver and table capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abc   <= '0;
      r_table <= '0;
    end else if (w_accept) begin
      r_abc   <= '0;
      r_table <= '0;
    end else if (w_driving) begin
      r_table <= w_table_cap;
      if (w_abort)
        r_abc <= '0;
      else if (w_capture)
        r_abc <= (r_abc == LAST) ? '0 : r_abc + WIDTH'(1);
    end
  end

`ifdef TRUTH_SCAN_COMPARE_EN
  logic [N-1:0] r_expected;
  logic         r_pass;

  // Latch the reference on start; judge the completed table on the last capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expected <= '0;
      r_pass     <= 1'b0;
    end else if (w_accept) begin
      r_expected <= expected;
      r_pass     <= 1'b0;
    end else if (w_end) begin
      r_pass     <= (w_table_cap == r_expected);
    end
  end

  assign pass = r_pass;
`else
  logic w_unused_expected;
  assign w_unused_expected = ^expected;
  assign pass = 1'b0;
`endif

  assign abc     = r_abc;
  assign table_q = r_table;
  assign busy    = w_driving;
  assign done    = (r_state == ST_DONE);

endmodule
